id_fwd_ctrl: RTL and testbench

ID_FWD_CTRL -- requirements
Module: id_fwd_ctrl

---
 rtl/id_fwd_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_id_fwd_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_fwd_ctrl.sv
// ID-stage operand forwarding and load/VDOT hazard stall control; optional perf counters under FWD_PERF_CNT_EN.
// Operands registered one cycle after acceptance; stall_ID is combinational and holds PC/IF/ID while sources are not ready.
module id_fwd_ctrl #(
    parameter int STALL_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_ID,
    input  logic [4:0]  rs1Addr_ID,
    input  logic [4:0]  rs2Addr_ID,
    input  logic        rs1Used_ID,
    input  logic        rs2Used_ID,
    input  logic [31:0] rs1Data_RF,
    input  logic [31:0] rs2Data_RF,
    input  logic [14:0] rdAddr_out,
    input  logic [2:0]  regWrite_out,
    input  logic [95:0] DATA_out,
    input  logic [5:0]  op_type_out,
    input  logic        flush,
    output logic        stall_ID,
    output logic [31:0] rs1Data_EXE,
    output logic [31:0] rs2Data_EXE,
    output logic        bubble_EXE,
    output logic [1:0]  fwd_sel1,
    output logic [1:0]  fwd_sel2,
    output logic        hazard_err
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] fwd_hits
`endif
);

    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_VDOT = 2'b10;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_STALL = 1'b1;

    localparam int CW = $clog2(STALL_MAX + 2);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(STALL_MAX);
    localparam logic [CW-1:0] CNT_SAT   = '1;

    // Result layout: {wait[1:0], sel[1:0], data[31:0]}; only the youngest matching stage is used.
    function automatic logic [35:0] resolve(
        input logic        used,
        input logic [4:0]  rs,
        input logic [31:0] rf,
        input logic [14:0] rd,
        input logic [2:0]  we,
        input logic [95:0] dat,
        input logic [5:0]  op
    );
        logic [1:0]  wt;
        logic [1:0]  sel;
        logic [31:0] d;
        logic        hit;
        wt  = 2'd0;
        sel = 2'd0;
        d   = rf;
        hit = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (!hit && used && (rs != 5'd0) && we[s] && (rd[5*s +: 5] == rs)) begin
                hit = 1'b1;
                sel = 2'(s + 1);
                d   = dat[32*s +: 32];
                if (s == 0 && op[1:0] == OP_LOAD) begin
                    wt = 2'd1;
                end else if (s == 0 && op[1:0] == OP_VDOT) begin
                    wt = 2'd2;
                end else if (s == 1 && op[3:2] == OP_VDOT) begin
                    wt = 2'd1;
                end
            end
        end
        return {wt, sel, d};
    endfunction

    logic [35:0]  res1;
    logic [35:0]  res2;
    logic [1:0]   wait1;
    logic [1:0]   wait2;
    logic [1:0]   wait_max;
    logic         accept;

    logic [0:0]   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         hazard_q, hazard_d;
    logic [31:0]  rs1_q, rs1_d;
    logic [31:0]  rs2_q, rs2_d;
    logic [1:0]   sel1_q, sel1_d;
    logic [1:0]   sel2_q, sel2_d;
    logic         bubble_q, bubble_d;

    always_comb begin
        res1     = resolve(rs1Used_ID, rs1Addr_ID, rs1Data_RF, rdAddr_out, regWrite_out, DATA_out, op_type_out);
        res2     = resolve(rs2Used_ID, rs2Addr_ID, rs2Data_RF, rdAddr_out, regWrite_out, DATA_out, op_type_out);
        wait1    = res1[35:34];
        wait2    = res2[35:34];
        wait_max = (wait1 > wait2) ? wait1 : wait2;
        // flush kills the ID instruction, so it can never stall
        stall_ID = valid_ID & ~flush & (wait_max != 2'd0);
        accept   = valid_ID & ~flush & ~stall_ID;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (stall_ID) begin
                    state_d = S_STALL;
                    cnt_d   = {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                if (stall_ID) begin
                    cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
        endcase
        hazard_d = hazard_q | (stall_ID & (cnt_d >= CNT_LIMIT));
    end

    always_comb begin
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        sel1_d   = sel1_q;
        sel2_d   = sel2_q;
        bubble_d = 1'b1;
        if (accept) begin
            rs1_d    = res1[31:0];
            rs2_d    = res2[31:0];
            sel1_d   = res1[33:32];
            sel2_d   = res2[33:32];
            bubble_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hazard_q <= 1'b0;
            rs1_q    <= 32'd0;
            rs2_q    <= 32'd0;
            sel1_q   <= 2'd0;
            sel2_q   <= 2'd0;
            bubble_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hazard_q <= hazard_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            sel1_q   <= sel1_d;
            sel2_q   <= sel2_d;
            bubble_q <= bubble_d;
        end
    end

    assign rs1Data_EXE = rs1_q;
    assign rs2Data_EXE = rs2_q;
    assign fwd_sel1    = sel1_q;
    assign fwd_sel2    = sel2_q;
    assign bubble_EXE  = bubble_q;
    assign hazard_err  = hazard_q;

`ifdef FWD_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] fwd_hits_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
            fwd_hits_q     <= 32'd0;
        end else begin
            if (stall_ID && stall_cycles_q != 32'hFFFF_FFFF) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (accept && (res1[33:32] != 2'd0 || res2[33:32] != 2'd0) && fwd_hits_q != 32'hFFFF_FFFF) begin
                fwd_hits_q <= fwd_hits_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign fwd_hits     = fwd_hits_q;
`endif

endmodule

// File: tb/tb_id_fwd_ctrl.sv
module tb_id_fwd_ctrl;

    localparam logic [1:0] ALU  = 2'b00;
    localparam logic [1:0] LOAD = 2'b01;
    localparam logic [1:0] VDOT = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_ID;
    logic [4:0]  rs1Addr_ID, rs2Addr_ID;
    logic        rs1Used_ID, rs2Used_ID;
    logic [31:0] rs1Data_RF, rs2Data_RF;
    logic [14:0] rdAddr_out;
    logic [2:0]  regWrite_out;
    logic [95:0] DATA_out;
    logic [5:0]  op_type_out;
    logic        flush;
    logic        stall_ID;
    logic [31:0] rs1Data_EXE, rs2Data_EXE;
    logic        bubble_EXE;
    logic [1:0]  fwd_sel1, fwd_sel2;
    logic        hazard_err;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [1:0]  s1;
        logic [1:0]  s2;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_e;
    exp_t mon_e;
    exp_t got_e;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    id_fwd_ctrl #(.STALL_MAX(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_ID     (valid_ID),
        .rs1Addr_ID   (rs1Addr_ID),
        .rs2Addr_ID   (rs2Addr_ID),
        .rs1Used_ID   (rs1Used_ID),
        .rs2Used_ID   (rs2Used_ID),
        .rs1Data_RF   (rs1Data_RF),
        .rs2Data_RF   (rs2Data_RF),
        .rdAddr_out   (rdAddr_out),
        .regWrite_out (regWrite_out),
        .DATA_out     (DATA_out),
        .op_type_out  (op_type_out),
        .flush        (flush),
        .stall_ID     (stall_ID),
        .rs1Data_EXE  (rs1Data_EXE),
        .rs2Data_EXE  (rs2Data_EXE),
        .bubble_EXE   (bubble_EXE),
        .fwd_sel1     (fwd_sel1),
        .fwd_sel2     (fwd_sel2),
        .hazard_err   (hazard_err)
    );

    // Scoreboard: each EXE result pops one expectation; bubbles must hold the last accepted values.
    always @(negedge clk) begin
        got_e = '{d1: rs1Data_EXE, d2: rs2Data_EXE, s1: fwd_sel1, s2: fwd_sel2};
        if (rst === 1'b1) begin
            last_e = '0;
        end else if (bubble_EXE === 1'b0) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: accepted %h/%h sel %0d/%0d, required no acceptance",
                         got_e.d1, got_e.d2, got_e.s1, got_e.s2);
            end else begin
                mon_e = sb_q.pop_front();
                if (got_e !== mon_e) begin
                    n_err++;
                    $display("FAIL sb_operands: got %h/%h sel %0d/%0d, required %h/%h sel %0d/%0d",
                             got_e.d1, got_e.d2, got_e.s1, got_e.s2, mon_e.d1, mon_e.d2, mon_e.s1, mon_e.s2);
                end
                last_e = mon_e;
            end
        end else if (bubble_EXE === 1'b1) begin
            n_cmp++;
            if (got_e !== last_e) begin
                n_err++;
                $display("FAIL bubble_hold: got %h/%h sel %0d/%0d, required %h/%h sel %0d/%0d",
                         got_e.d1, got_e.d2, got_e.s1, got_e.s2, last_e.d1, last_e.d2, last_e.s1, last_e.s2);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pipe;
        rdAddr_out   = '0;
        regWrite_out = '0;
        DATA_out     = '0;
        op_type_out  = '0;
    endtask

    task automatic set_stage(input int s, input logic [4:0] rd, input logic [1:0] op, input logic [31:0] d);
        rdAddr_out[5*s +: 5]  = rd;
        regWrite_out[s]       = 1'b1;
        op_type_out[2*s +: 2] = op;
        DATA_out[32*s +: 32]  = d;
    endtask

    task automatic set_id(input logic v,
                          input logic u1, input logic [4:0] a1, input logic [31:0] r1,
                          input logic u2, input logic [4:0] a2, input logic [31:0] r2);
        valid_ID   = v;
        rs1Used_ID = u1;
        rs1Addr_ID = a1;
        rs1Data_RF = r1;
        rs2Used_ID = u2;
        rs2Addr_ID = a2;
        rs2Data_RF = r2;
    endtask

    task automatic push(input logic [31:0] d1, input logic [31:0] d2, input logic [1:0] s1, input logic [1:0] s2);
        sb_q.push_back('{d1: d1, d2: d2, s1: s1, s2: s2});
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({rs1Data_EXE, rs2Data_EXE} !== 64'd0) begin
            n_err++;
            $display("FAIL reset_data: got %h/%h, required 0/0", rs1Data_EXE, rs2Data_EXE);
        end
        n_cmp++;
        if ({fwd_sel1, fwd_sel2, bubble_EXE, hazard_err, stall_ID} !== 7'b0000_100) begin
            n_err++;
            $display("FAIL reset_ctrl: sel %0d/%0d bubble %b err %b stall %b, required 0/0 1 0 0",
                     fwd_sel1, fwd_sel2, bubble_EXE, hazard_err, stall_ID);
        end
    endtask

    task automatic test_exe_alu;
        clear_pipe();
        set_stage(0, 5'd5, ALU, 32'h11);
        set_id(1'b1, 1'b1, 5'd5, 32'hDEAD, 1'b1, 5'd9, 32'h22);
        push(32'h11, 32'h22, 2'd1, 2'd0);
        #1;
        n_cmp++;
        if (stall_ID !== 1'b0) begin
            n_err++;
            $display("FAIL alu_nostall: stall_ID %b, required 0", stall_ID);
        end
        tick();
        set_id(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_cmp++;
        if (bubble_EXE !== 1'b0) begin
            n_err++;
            $display("FAIL alu_accept: bubble_EXE %b, required 0", bubble_EXE);
        end
        tick();
    endtask

    task automatic test_load_stall;
        clear_pipe();
        set_stage(0, 5'd7, LOAD, 32'hBAD0);
        set_id(1'b1, 1'b0, 5'd0, 32'h1111, 1'b1, 5'd7, 32'h2222);
        #1;
        n_cmp++;
        if (stall_ID !== 1'b1) begin
            n_err++;
            $display("FAIL load_stall: stall_ID %b, required 1", stall_ID);
        end
        tick();
        n_cmp++;
        if (bubble_EXE !== 1'b1) begin
            n_err++;
            $display("FAIL load_bubble: bubble_EXE %b, required 1", bubble_EXE);
        end
        clear_pipe();
        set_stage(1, 5'd7, LOAD, 32'h7700);
        push(32'h1111, 32'h7700, 2'd0, 2'd2);
        #1;
        n_cmp++;
        if (stall_ID !== 1'b0) begin
            n_err++;
            $display("FAIL load_release: stall_ID %b, required 0", stall_ID);
        end
        tick();
        set_id(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
    endtask

    task automatic test_vdot;
        clear_pipe();
        set_stage(0, 5'd3, VDOT, 32'h0);
        set_id(1'b1, 1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd8, 32'h8888);
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++;
            if (stall_ID !== 1'b1) begin
                n_err++;
                $display("FAIL vdot_stall%0d: stall_ID %b, required 1", k, stall_ID);
            end
            tick();
            clear_pipe();
            if (k == 0) set_stage(1, 5'd3, VDOT, 32'h0);
            else        set_stage(2, 5'd3, VDOT, 32'hD07D07);
        end
        push(32'hD07D07, 32'h8888, 2'd3, 2'd0);
        #1;
        n_cmp++;
        if (stall_ID !== 1'b0) begin
            n_err++;
            $display("FAIL vdot_release: stall_ID %b, required 0", stall_ID);
        end
        tick();
        set_id(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_cmp++;
        if (hazard_err !== 1'b0) begin
            n_err++;
            $display("FAIL vdot_noerr: hazard_err %b, required 0", hazard_err);
        end
        tick();
    endtask

    task automatic test_priority;
        clear_pipe();
        set_stage(0, 5'd4, ALU, 32'hA);
        set_stage(1, 5'd4, ALU, 32'hB);
        set_stage(2, 5'd4, ALU, 32'hC);
        set_id(1'b1, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 32'h45);
        push(32'hA, 32'hA, 2'd1, 2'd1);
        tick();
        clear_pipe();
        set_stage(1, 5'd4, LOAD, 32'hB);
        set_stage(2, 5'd4, ALU, 32'hC);
        set_id(1'b1, 1'b1, 5'd4, 32'h44, 1'b0, 5'd4, 32'h45);
        push(32'hB, 32'h45, 2'd2, 2'd0);
        tick();
        clear_pipe();
        set_stage(0, 5'd0, ALU, 32'h55);
        set_stage(1, 5'd0, ALU, 32'h66);
        set_id(1'b1, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h5678);
        push(32'h1234, 32'h5678, 2'd0, 2'd0);
        tick();
        clear_pipe();
        set_stage(0, 5'd4, VDOT, 32'hA);
        set_stage(1, 5'd4, ALU, 32'hB);
        set_id(1'b1, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0);
        #1;
        n_cmp++;
        if (stall_ID !== 1'b1) begin
            n_err++;
            $display("FAIL youngest_only: stall_ID %b, required 1", stall_ID);
        end
        clear_pipe();
        set_id(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
    endtask

    task automatic test_hazard_err;
        clear_pipe();
        set_stage(0, 5'd7, LOAD, 32'h0);
        set_id(1'b1, 1'b0, 5'd0, 32'h1, 1'b1, 5'd7, 32'h2);
        for (int k = 1; k <= 4; k++) begin
            #1;
            n_cmp++;
            if (stall_ID !== 1'b1) begin
                n_err++;
                $display("FAIL held_stall%0d: stall_ID %b, required 1", k, stall_ID);
            end
            tick();
            n_cmp++;
            if (hazard_err !== (k >= 3)) begin
                n_err++;
                $display("FAIL hazard_err%0d: got %b, required %b", k, hazard_err, (k >= 3));
            end
        end
        flush = 1'b1;
        #1;
        n_cmp++;
        if (stall_ID !== 1'b0) begin
            n_err++;
            $display("FAIL flush_stall: stall_ID %b, required 0", stall_ID);
        end
        tick();
        flush = 1'b0;
        n_cmp++;
        if ({bubble_EXE, hazard_err} !== 2'b11) begin
            n_err++;
            $display("FAIL flush_bubble: bubble %b err %b, required 1 1", bubble_EXE, hazard_err);
        end
        clear_pipe();
        set_id(1'b1, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h77);
        push(32'h66, 32'h77, 2'd0, 2'd0);
        tick();
        set_id(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
    endtask

    task automatic test_rst_mid_stall;
        clear_pipe();
        set_stage(0, 5'd9, LOAD, 32'h0);
        set_id(1'b1, 1'b1, 5'd9, 32'h9, 1'b0, 5'd0, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (stall_ID !== 1'b1) begin
            n_err++;
            $display("FAIL rst_stall_comb: stall_ID %b, required 1", stall_ID);
        end
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({hazard_err, bubble_EXE, rs1Data_EXE} !== {1'b0, 1'b1, 32'd0}) begin
            n_err++;
            $display("FAIL rst_mid_stall: err %b bubble %b rs1 %h, required 0 1 0", hazard_err, bubble_EXE, rs1Data_EXE);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_cmp++;
            if (hazard_err !== (k >= 3)) begin
                n_err++;
                $display("FAIL rst_recount%0d: hazard_err %b, required %b", k, hazard_err, (k >= 3));
            end
        end
        clear_pipe();
        set_id(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        int          s;
        logic [4:0]  a;
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            s = i % 4;
            a = 5'(i + 1);
            clear_pipe();
            if (s > 0) set_stage(s - 1, a, (s == 2) ? LOAD : ALU, 32'h100 + 32'(i));
            set_id(1'b1, 1'b1, a, 32'h900 + 32'(i), 1'b1, a, 32'h900 + 32'(i));
            flush = (i == 5);
            d = (s > 0) ? 32'h100 + 32'(i) : 32'h900 + 32'(i);
            if (i != 5) push(d, d, 2'(s), 2'(s));
            tick();
            n_cmp++;
            if (bubble_EXE !== (i == 5)) begin
                n_err++;
                $display("FAIL b2b_bubble%0d: bubble_EXE %b, required %b", i, bubble_EXE, (i == 5));
            end
        end
        flush = 1'b0;
        clear_pipe();
        set_id(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        clear_pipe();
        set_id(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        test_reset();
        test_exe_alu();
        test_load_stall();
        test_vdot();
        test_priority();
        test_hazard_err();
        test_rst_mid_stall();
        test_back_to_back();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d expected results never produced, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
